// File: rtl/iq_stream_pkg.sv
// ---------------------------------------------------------------------------
// iq_stream_pkg
// Shared definitions for the IQ burst unpacker: default stream geometry and
// the burst-framing state encoding used by iq_burst_unpacker.
// ---------------------------------------------------------------------------
package iq_stream_pkg;

    localparam int RW    = 20;  // width of one signed I or Q word
    localparam int NCHAN = 4;   // channels per burst (burst = 2*NCHAN words)
    localparam int FCW   = 16;  // frame counter width

    // SYNC waits out any burst already in flight when reset is released,
    // so a partial burst is never mistaken for a fresh one.
    typedef enum logic [1:0] {
        ST_SYNC     = 2'd0,
        ST_IDLE     = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_OVERLONG = 2'd3
    } unpack_state_t;

endpackage

// File: rtl/iq_shadow_bank.sv
// ---------------------------------------------------------------------------
// iq_shadow_bank
// Register file holding one burst as it arrives, plus the committed frame.
// The whole shadow is copied to 'flat' on a single edge, so the committed
// frame is never seen half old, half new.
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en        : write wr_data into shadow entry wr_idx
//   wr_idx       : shadow entry index
//   wr_data      : stream word
//   copy_en      : copy every shadow entry to flat on this edge
//   flat         : committed frame, entry k at bits [k*rw +: rw]
// ---------------------------------------------------------------------------
module iq_shadow_bank #(
    parameter int rw    = 20,
    parameter int depth = 8,
    parameter int aw    = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [aw-1:0]         wr_idx,
    input  logic [rw-1:0]         wr_data,
    input  logic                  copy_en,
    output logic [depth*rw-1:0]   flat
);

    logic [rw-1:0] shadow_r [depth];

    // Indexed capture of incoming words into the shadow entries
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < depth; k++) begin
                shadow_r[k] <= '0;
            end
        end else if (wr_en) begin
            shadow_r[wr_idx] <= wr_data;
        end
    end

    // Atomic transfer of the complete shadow into the committed frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flat <= '0;
        end else if (copy_en) begin
            for (int k = 0; k < depth; k++) begin
                flat[k*rw +: rw] <= shadow_r[k];
            end
        end
    end

endmodule

// File: rtl/iq_burst_unpacker.sv
// ---------------------------------------------------------------------------
// iq_burst_unpacker
// Collects strobe-framed bursts of 2*nchan signed IQ words into a flat frame.
// A burst of exactly 2*nchan words is committed on the edge that samples
// strobe_cc low after its last word; wrong-length bursts raise err_len and
// are dropped. Committing over an unacknowledged frame raises err_overrun.
//   clk, reset_n : clock, asynchronous active-low reset
//   result_iq    : stream word (I0,Q0,I1,Q1,...) valid while strobe_cc high
//   strobe_cc    : burst framing
//   freeze       : suppress the commit of a burst ending on this edge
//   frame_ack    : consumer has taken the current frame
//   clr_err      : clear sticky error flags
//   iq_flat      : committed frame, word k at bits [k*rw +: rw]
//   frame_valid  : committed frame not yet acknowledged
//   frame_cnt    : committed frame count (wrapping)
//   err_len      : sticky wrong-burst-length flag
//   err_overrun  : sticky overwrite-of-unacknowledged-frame flag
// ---------------------------------------------------------------------------
module iq_burst_unpacker
    import iq_stream_pkg::*;
#(
    parameter int rw    = RW,
    parameter int nchan = NCHAN,
    parameter int fcw   = FCW
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [rw-1:0]           result_iq,
    input  logic                    strobe_cc,
    input  logic                    freeze,
    input  logic                    frame_ack,
    input  logic                    clr_err,
    output logic [2*nchan*rw-1:0]   iq_flat,
    output logic                    frame_valid,
    output logic [fcw-1:0]          frame_cnt,
    output logic                    err_len,
    output logic                    err_overrun
);

    localparam int blen = 2 * nchan;
    localparam int iw   = $clog2(blen + 1);   // index must reach blen itself
    localparam int aw   = $clog2(blen);
    localparam logic [iw-1:0] idx_full = iw'(blen);

    unpack_state_t  state_r, state_nxt_s;
    logic [iw-1:0]  idx_r, idx_nxt_s;
    logic           wr_en_s;
    logic [aw-1:0]  wr_idx_s;
    logic           burst_done_s;
    logic           len_evt_s;
    logic           commit_s;
    logic           overrun_evt_s;

    // Burst framing: next state, shadow write control and burst events
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        wr_en_s      = 1'b0;
        wr_idx_s     = idx_r[aw-1:0];
        burst_done_s = 1'b0;
        len_evt_s    = 1'b0;
        case (state_r)
            ST_SYNC: begin
                if (!strobe_cc) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SYNC;
                end
                idx_nxt_s = '0;
            end
            ST_IDLE: begin
                if (strobe_cc) begin
                    state_nxt_s = ST_CAPTURE;
                    wr_en_s     = 1'b1;
                    wr_idx_s    = '0;
                    idx_nxt_s   = iw'(1);
                end else begin
                    idx_nxt_s   = '0;
                end
            end
            ST_CAPTURE: begin
                if (strobe_cc) begin
                    if (idx_r < idx_full) begin
                        wr_en_s   = 1'b1;
                        idx_nxt_s = idx_r + iw'(1);
                    end else begin
                        // word L+1: the burst is too long, drop the rest
                        state_nxt_s = ST_OVERLONG;
                        len_evt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = '0;
                    if (idx_r == idx_full) begin
                        burst_done_s = 1'b1;
                    end else begin
                        len_evt_s    = 1'b1;
                    end
                end
            end
            ST_OVERLONG: begin
                if (!strobe_cc) begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_OVERLONG;
                end
            end
            default: begin
                state_nxt_s = ST_SYNC;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // Commit qualification; an ack on the commit edge hands the old frame
    // over in time, so it is not an overrun.
    always_comb begin
        commit_s      = burst_done_s & ~freeze;
        overrun_evt_s = commit_s & frame_valid & ~frame_ack;
    end

    // State and word index registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_SYNC;
            idx_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Frame handshake and frame counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
        end else if (commit_s) begin
            frame_valid <= 1'b1;
            frame_cnt   <= frame_cnt + fcw'(1);
        end else if (frame_ack) begin
            frame_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_len     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (len_evt_s) begin
                err_len <= 1'b1;
            end else if (clr_err) begin
                err_len <= 1'b0;
            end
            if (overrun_evt_s) begin
                err_overrun <= 1'b1;
            end else if (clr_err) begin
                err_overrun <= 1'b0;
            end
        end
    end

    iq_shadow_bank #(
        .rw    (rw),
        .depth (blen),
        .aw    (aw)
    ) u_shadow_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en_s),
        .wr_idx  (wr_idx_s),
        .wr_data (result_iq),
        .copy_en (commit_s),
        .flat    (iq_flat)
    );

endmodule

// File: tb/tb_iq_burst_unpacker.sv
`timescale 1ns/1ps
module tb_iq_burst_unpacker;

    localparam int RW = 20;
    localparam int L  = 8;
    localparam int FW = L * RW;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [RW-1:0]     result_iq;
    logic              strobe_cc;
    logic              freeze;
    logic              frame_ack;
    logic              clr_err;
    logic [FW-1:0]     iq_flat;
    logic              frame_valid;
    logic [15:0]       frame_cnt;
    logic              err_len;
    logic              err_overrun;

    int tests = 0;
    int fails = 0;

    // stimulus word table for the next burst
    logic [RW-1:0] wv [16];

    // behavioural model state
    logic [RW-1:0] m_flat [L];
    logic [RW-1:0] m_buf  [L];
    int            m_count;
    bit            m_skip;
    logic          m_valid;
    logic [15:0]   m_cnt;
    logic          m_err_len;
    logic          m_err_ovr;

    always #5 clk = ~clk;

    iq_burst_unpacker #(.rw(RW), .nchan(4), .fcw(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .result_iq   (result_iq),
        .strobe_cc   (strobe_cc),
        .freeze      (freeze),
        .frame_ack   (frame_ack),
        .clr_err     (clr_err),
        .iq_flat     (iq_flat),
        .frame_valid (frame_valid),
        .frame_cnt   (frame_cnt),
        .err_len     (err_len),
        .err_overrun (err_overrun)
    );

    task automatic chk(input string nm, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model: counts the words of each strobe run; a run of exactly L words
    // followed by a low cycle is a frame, anything else is a length error.
    always @(posedge clk or negedge reset_n) begin
        bit commit, len_evt, ovr_evt;
        if (!reset_n) begin
            for (int k = 0; k < L; k++) begin
                m_flat[k] = '0;
                m_buf[k]  = '0;
            end
            m_count   = 0;
            m_skip    = 1'b1;
            m_valid   = 1'b0;
            m_cnt     = 16'd0;
            m_err_len = 1'b0;
            m_err_ovr = 1'b0;
        end else begin
            commit  = 1'b0;
            len_evt = 1'b0;
            ovr_evt = 1'b0;
            if (m_skip) begin
                if (!strobe_cc) m_skip = 1'b0;
            end else if (strobe_cc) begin
                if (m_count < L) m_buf[m_count] = result_iq;
                if (m_count <= L) begin
                    m_count++;
                    if (m_count == L + 1) len_evt = 1'b1;
                end
            end else begin
                if (m_count == L) commit = !freeze;
                else if (m_count > 0 && m_count < L) len_evt = 1'b1;
                m_count = 0;
            end
            if (commit) begin
                ovr_evt = m_valid && !frame_ack;
                m_flat  = m_buf;
                m_cnt   = m_cnt + 16'd1;
                m_valid = 1'b1;
            end else if (frame_ack) begin
                m_valid = 1'b0;
            end
            if (len_evt) m_err_len = 1'b1;
            else if (clr_err) m_err_len = 1'b0;
            if (ovr_evt) m_err_ovr = 1'b1;
            else if (clr_err) m_err_ovr = 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model, just after each edge
    always @(posedge clk) begin
        logic [FW-1:0] exp_flat;
        #1;
        for (int k = 0; k < L; k++) exp_flat[k*RW +: RW] = m_flat[k];
        chk("iq_flat", iq_flat, exp_flat);
        chk("frame_valid", FW'(frame_valid), FW'(m_valid));
        chk("frame_cnt", FW'(frame_cnt), FW'(m_cnt));
        chk("err_len", FW'(err_len), FW'(m_err_len));
        chk("err_overrun", FW'(err_overrun), FW'(m_err_ovr));
    end

    task automatic fill(input int base);
        for (int i = 0; i < 16; i++) wv[i] = RW'(base + i);
    endtask

    // n words, then exactly one low cycle carrying the given side inputs
    task automatic burst(input int n, input logic frz, input logic ack, input logic clr);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            strobe_cc = 1'b1;
            result_iq = wv[i];
        end
        @(negedge clk);
        strobe_cc = 1'b0;
        result_iq = '0;
        freeze    = frz;
        frame_ack = ack;
        clr_err   = clr;
        @(negedge clk);
        freeze    = 1'b0;
        frame_ack = 1'b0;
        clr_err   = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge clk); frame_ack = 1'b1;
        @(negedge clk); frame_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
    endtask

    initial begin
        logic [FW-1:0] lit;
        reset_n   = 1'b0;
        result_iq = '0;
        strobe_cc = 1'b0;
        freeze    = 1'b0;
        frame_ack = 1'b0;
        clr_err   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_flat", iq_flat, '0);
        chk("reset_valid", FW'(frame_valid), FW'(1'b0));
        chk("reset_cnt", FW'(frame_cnt), FW'(16'd0));
        reset_n = 1'b1;
        @(negedge clk);

        // basic frame 1..8, committed one cycle after the last word
        fill(1);
        burst(8, 1'b0, 1'b0, 1'b0);
        lit = {20'd8, 20'd7, 20'd6, 20'd5, 20'd4, 20'd3, 20'd2, 20'd1};
        chk("lit_frame1", iq_flat, lit);
        chk("lit_valid1", FW'(frame_valid), FW'(1'b1));
        chk("lit_cnt1", FW'(frame_cnt), FW'(16'd1));
        pulse_ack();
        chk("lit_ack", FW'(frame_valid), FW'(1'b0));
        pulse_ack();   // ack with nothing pending is ignored

        // short burst: error, nothing committed; next burst is fine
        fill(50);
        burst(7, 1'b0, 1'b0, 1'b0);
        chk("lit_short_err", FW'(err_len), FW'(1'b1));
        chk("lit_short_cnt", FW'(frame_cnt), FW'(16'd1));
        chk("lit_short_flat", iq_flat, lit);
        fill(11);
        burst(8, 1'b0, 1'b0, 1'b0);
        chk("lit_after_short_cnt", FW'(frame_cnt), FW'(16'd2));
        pulse_ack();
        pulse_clr();
        chk("lit_clr", FW'(err_len), FW'(1'b0));

        // overlong burst
        fill(70);
        burst(10, 1'b0, 1'b0, 1'b0);
        chk("lit_long_err", FW'(err_len), FW'(1'b1));
        chk("lit_long_cnt", FW'(frame_cnt), FW'(16'd2));
        pulse_clr();

        // back-to-back bursts without ack: overrun
        fill(21);
        burst(8, 1'b0, 1'b0, 1'b0);
        fill(31);
        burst(8, 1'b0, 1'b0, 1'b0);
        chk("lit_ovr", FW'(err_overrun), FW'(1'b1));
        chk("lit_ovr_cnt", FW'(frame_cnt), FW'(16'd4));
        chk("lit_ovr_w0", FW'(iq_flat[19:0]), FW'(20'd31));
        chk("lit_ovr_w7", FW'(iq_flat[159:140]), FW'(20'd38));
        pulse_clr();
        pulse_ack();

        // same again but acked on the second commit edge
        fill(41);
        burst(8, 1'b0, 1'b0, 1'b0);
        fill(51);
        burst(8, 1'b0, 1'b1, 1'b0);
        chk("lit_ack_commit_ovr", FW'(err_overrun), FW'(1'b0));
        chk("lit_ack_commit_valid", FW'(frame_valid), FW'(1'b1));
        chk("lit_ack_commit_cnt", FW'(frame_cnt), FW'(16'd6));
        pulse_ack();

        // freeze drops the burst; extreme values pass bit-exact
        fill(90);
        burst(8, 1'b1, 1'b0, 1'b0);
        chk("lit_freeze_cnt", FW'(frame_cnt), FW'(16'd6));
        chk("lit_freeze_valid", FW'(frame_valid), FW'(1'b0));
        fill(0);
        wv[0] = 20'h80000;
        wv[1] = 20'h7FFFF;
        wv[2] = 20'hFFFFF;
        burst(8, 1'b0, 1'b0, 1'b0);
        chk("lit_min", FW'(iq_flat[19:0]), FW'(20'h80000));
        chk("lit_max", FW'(iq_flat[39:20]), FW'(20'h7FFFF));
        chk("lit_m1", FW'(iq_flat[59:40]), FW'(20'hFFFFF));
        chk("lit_ext_cnt", FW'(frame_cnt), FW'(16'd7));

        // clear and new error on the same edge: error wins
        burst(7, 1'b0, 1'b0, 1'b1);
        chk("lit_clr_vs_err", FW'(err_len), FW'(1'b1));

        // reset in the middle of a burst
        fill(101);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); strobe_cc = 1'b1; result_iq = wv[i];
        end
        @(negedge clk); reset_n = 1'b0; result_iq = wv[3];
        @(negedge clk); result_iq = wv[4];
        @(negedge clk); reset_n = 1'b1; result_iq = wv[5];
        @(negedge clk); result_iq = wv[6];
        @(negedge clk); result_iq = wv[7];
        @(negedge clk); strobe_cc = 1'b0; result_iq = '0;
        repeat (2) @(negedge clk);
        chk("lit_rst_err", FW'(err_len), FW'(1'b0));
        chk("lit_rst_cnt", FW'(frame_cnt), FW'(16'd0));
        chk("lit_rst_valid", FW'(frame_valid), FW'(1'b0));
        fill(201);
        burst(8, 1'b0, 1'b0, 1'b0);
        chk("lit_rst_next_cnt", FW'(frame_cnt), FW'(16'd1));
        chk("lit_rst_next_w0", FW'(iq_flat[19:0]), FW'(20'd201));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
